mem_arbiter: RTL and testbench
==============================

# mem_arbiter

The memory arbiter shares one backing-memory port between the L1 instruction-cache refill path and the L1 data-cache read/write path. It sits between both `l1` instances and the `memory_controller` backing port. It converts level requests into single outstanding memory transactions, gives data accesses priority, and uses a starvation limit so instruction fetch always makes forward progress. It returns per-requester data with a one-cycle `done` pulse and drives the `stall_l1i` / `stall_l1d` signals the pipeline already consumes.

## Interface
- `STARVE_LIMIT`, default 4: consecutive arbitration losses of a pending L1I request, after which L1I wins the next arbitration.
- `clock`  in  1  pipeline clock (`cpu_clock` domain).
- `reset_n`  in  1  synchronous, active-low reset.
- `l1i_req`  in  1  instruction refill request (level; held until `l1i_done`).
- `l1i_address`  in  32  fetch address.
- `l1i_rdata`  out  32  returned instruction word, valid while `l1i_done`.
- `l1i_done`  out  1  one-cycle completion pulse.
- `stall_l1i`  out  1  `l1i_req & ~l1i_done`.
- `l1d_req`  in  1  data request (level; held until `l1d_done`).
- `l1d_write`  in  1  1 = store, 0 = load.
- `l1d_address`  in  32  data address.
- `l1d_wdata`  in  32  store data.
- `l1d_rdata`  out  32  load data, valid while `l1d_done`; 0 for stores.
- `l1d_done`  out  1  one-cycle completion pulse.
- `stall_l1d`  out  1  `l1d_req & ~l1d_done`.
- `mem_valid`  out  1  backing-port request, held until `mem_ack`.
- `mem_write`  out  1  store qualifier.
- `mem_address`  out  32  port address.
- `mem_wdata`  out  32  port store data.
- `mem_ack`  in  1  port completion; may be asserted in the same cycle `mem_valid` first rises.
- `mem_rdata`  in  32  port load data, valid with `mem_ack`.
- `data_source`  out  2  owner of the current/last grant: `SRC_NONE`, `SRC_L1I`, `SRC_L1D`.

## Operation
- FSM states: `IDLE`, `BUSY`, `RESPOND`.
- **`IDLE`, arbitration:**
  - Only `l1d_req`: grant L1D.
  - Only `l1i_req`: grant L1I.
  - Both asserted: grant L1D, unless `starve_cnt == STARVE_LIMIT`, in which case grant L1I.
  - On any grant: latch owner, address, write flag and wdata into registers, then go to `BUSY`.
- **Starvation counter:** `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`) increments, saturating, each time L1I loses arbitration while pending. It clears when L1I is granted.
- **`BUSY`:**
  - `mem_valid=1`; `mem_*` are driven from the latched registers only and stay stable until ack.
  - On `mem_ack`: capture `mem_rdata` (or 0 for a write) into the owner's rdata register, then go to `RESPOND`.
- **`RESPOND`:**
  - Pulse the owner's `done` for exactly one cycle, then go to `IDLE`.
  - Back-to-back grants are not possible: at least one `IDLE` cycle separates transactions.
- **Abandonment:** if the owner's `req` is low in `RESPOND` (e.g. the fetch was flushed by a branch), the `done` pulse and rdata update are suppressed. The memory transaction itself always completes; `mem_valid` is never withdrawn before `mem_ack`.
- **`data_source`:** holds the last owner, and is `SRC_NONE` only after reset until the first grant.

## Timing
- **Reset (`reset_n=0` at an edge):**
  - State goes to `IDLE` and `starve_cnt` to 0.
  - `mem_valid`, `mem_write`, both `done` = 0.
  - `mem_address`, `mem_wdata`, both rdata = 0.
  - `data_source` = `SRC_NONE`.
- **Reset mid-operation:** `mem_valid` drops at that edge. An ack arriving afterwards is ignored.
- **Latency:**
  - Request seen in `IDLE` at edge N → `mem_valid` high after edge N.
  - Ack in the first `BUSY` cycle → `done` high after edge N+1.
  - Minimum total is 2 cycles; each extra ack wait cycle adds 1.
- **Stall outputs:**
  - Combinational from `req`/`done`, so a requester's stall falls in the same cycle as its `done`.
  - The non-owner's stall stays high throughout.
- **`l1d_write` / address changes while not granted:** harmless; values are sampled only at grant.

## Structure
- Shared package `mem_pkg`:
  - Source encodings `SRC_NONE=2'd0`, `SRC_L1I=2'd1`, `SRC_L1D=2'd2`.
  - FSM state typedef.
  - Reuses the existing `DATA_SOURCE_*` naming style.
- One sub-module, `starve_counter`: a saturating counter with `inc`/`clr` inputs and a `limit_hit` output. Everything else is flat.

## Test plan
- **Single L1I read:** `l1i_req=1`, addr `0x100`, memory acks after 3 cycles with `0xDEADBEEF` → `mem_valid` high 3 cycles, `l1i_done` one pulse, `l1i_rdata=0xDEADBEEF`, `data_source=SRC_L1I`.
- **L1D store with zero-wait ack:** `l1d_req=1`, `l1d_write=1`, addr `0x2000`, wdata `0x12345678` → `mem_write=1`, `mem_wdata=0x12345678`, `l1d_done` 2 cycles after request, `l1d_rdata=0`.
- **Simultaneous requests, `STARVE_LIMIT=4`:** both reqs held, L1D re-requesting every transaction → L1D wins 4 grants, 5th grant goes to L1I, `starve_cnt` returns to 0.
- **Flush mid-fetch:** `l1i_req` dropped while `BUSY` → `mem_valid` held until ack, no `l1i_done` pulse, FSM back in `IDLE` 1 cycle after `RESPOND`.
- **Reset during `BUSY`:** `reset_n=0` for 1 cycle → all outputs 0 next cycle, `data_source=SRC_NONE`; a late `mem_ack` produces no `done`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and encodings for the L1I/L1D memory arbiter.
// Source encodings follow the existing DATA_SOURCE_* style.
package mem_pkg;

  typedef logic [1:0] data_source_t;

  localparam data_source_t SRC_NONE = 2'd0;
  localparam data_source_t SRC_L1I  = 2'd1;
  localparam data_source_t SRC_L1D  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  // Counter width able to hold the value `limit` itself.
  function automatic int starve_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of consecutive arbitration losses by a pending L1I request.
// limit_hit tells the arbiter that instruction fetch must win the next grant.
module starve_counter
  import mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);

  localparam int W = starve_width(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !limit_hit) begin
      count <= count + 1'b1;
    end
  end

  assign limit_hit = (count == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between L1I refills and L1D accesses.
// Data wins by default; a starvation limit guarantees fetch forward progress.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        l1i_req,
  input  logic [31:0] l1i_address,
  output logic [31:0] l1i_rdata,
  output logic        l1i_done,
  output logic        stall_l1i,

  input  logic        l1d_req,
  input  logic        l1d_write,
  input  logic [31:0] l1d_address,
  input  logic [31:0] l1d_wdata,
  output logic [31:0] l1d_rdata,
  output logic        l1d_done,
  output logic        stall_l1d,

  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,

  output logic [1:0]  data_source
);

  arb_state_t   state;
  arb_state_t   state_next;

  data_source_t owner;
  logic [31:0]  address_q;
  logic [31:0]  wdata_q;
  logic         write_q;
  logic [31:0]  resp_q;
  logic [31:0]  l1i_rdata_q;
  logic [31:0]  l1d_rdata_q;

  logic         limit_hit;
  logic         any_req;
  logic         grant_l1d;
  logic         grant_l1i;

  assign any_req   = l1i_req | l1d_req;
  assign grant_l1d = l1d_req & ~(l1i_req & limit_hit);
  assign grant_l1i = l1i_req & ~grant_l1d;

  // Losses and clears only count at an actual arbitration decision in IDLE.
  starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset_n  (reset_n),
    .inc      ((state == IDLE) & l1i_req & grant_l1d),
    .clr      ((state == IDLE) & grant_l1i),
    .limit_hit(limit_hit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ack) state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_write = 1'b0;
    l1i_done  = 1'b0;
    l1d_done  = 1'b0;
    case (state)
      BUSY: begin
        mem_valid = 1'b1;
        mem_write = write_q;
      end
      RESPOND: begin
        l1i_done = (owner == SRC_L1I) & l1i_req;
        l1d_done = (owner == SRC_L1D) & l1d_req;
      end
      default: ;
    endcase
  end

  // The response is held aside until RESPOND so an abandoned request leaves
  // the requester's visible rdata untouched.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner       <= SRC_NONE;
      address_q   <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      resp_q      <= '0;
      l1i_rdata_q <= '0;
      l1d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= grant_l1d ? SRC_L1D : SRC_L1I;
            address_q <= grant_l1d ? l1d_address : l1i_address;
            write_q   <= grant_l1d & l1d_write;
            wdata_q   <= grant_l1d ? l1d_wdata : '0;
          end
        end
        BUSY: begin
          if (mem_ack) resp_q <= write_q ? '0 : mem_rdata;
        end
        RESPOND: begin
          if (l1i_done) l1i_rdata_q <= resp_q;
          if (l1d_done) l1d_rdata_q <= resp_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_address = address_q;
  assign mem_wdata   = wdata_q;
  assign data_source = owner;

  assign l1i_rdata = l1i_done ? resp_q : l1i_rdata_q;
  assign l1d_rdata = l1d_done ? resp_q : l1d_rdata_q;

  assign stall_l1i = l1i_req & ~l1i_done;
  assign stall_l1d = l1d_req & ~l1d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table rows for single transactions and
// hand sequences for starvation, flush and reset-during-BUSY.
module tb_mem_arbiter;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_L1I  = 2'd1;
  localparam logic [1:0] SRC_L1D  = 2'd2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        l1i_req;
  logic [31:0] l1i_address;
  logic [31:0] l1i_rdata;
  logic        l1i_done;
  logic        stall_l1i;
  logic        l1d_req;
  logic        l1d_write;
  logic [31:0] l1d_address;
  logic [31:0] l1d_wdata;
  logic [31:0] l1d_rdata;
  logic        l1d_done;
  logic        stall_l1d;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  data_source;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .l1i_req    (l1i_req),
    .l1i_address(l1i_address),
    .l1i_rdata  (l1i_rdata),
    .l1i_done   (l1i_done),
    .stall_l1i  (stall_l1i),
    .l1d_req    (l1d_req),
    .l1d_write  (l1d_write),
    .l1d_address(l1d_address),
    .l1d_wdata  (l1d_wdata),
    .l1d_rdata  (l1d_rdata),
    .l1d_done   (l1d_done),
    .stall_l1d  (stall_l1d),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .data_source(data_source)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
  } ins_t;

  typedef struct {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic [1:0]  src;
  } outs_t;

  typedef struct {
    ins_t  stim;
    outs_t exp;
  } vec_t;

  function automatic ins_t mk_in(logic rst_n, logic i_req, logic [31:0] i_addr,
                                 logic d_req, logic d_wr, logic [31:0] d_addr,
                                 logic [31:0] d_wdata, logic ack, logic [31:0] rdata);
    ins_t s;
    s.rst_n = rst_n;  s.i_req = i_req;  s.i_addr = i_addr;
    s.d_req = d_req;  s.d_wr = d_wr;    s.d_addr = d_addr;
    s.d_wdata = d_wdata;  s.ack = ack;  s.rdata = rdata;
    return s;
  endfunction

  function automatic outs_t mk_out(logic valid, logic write, logic [31:0] addr,
                                   logic [31:0] wdata, logic i_done, logic [31:0] i_rdata,
                                   logic i_stall, logic d_done, logic [31:0] d_rdata,
                                   logic d_stall, logic [1:0] src);
    outs_t e;
    e.valid = valid;  e.write = write;  e.addr = addr;  e.wdata = wdata;
    e.i_done = i_done;  e.i_rdata = i_rdata;  e.i_stall = i_stall;
    e.d_done = d_done;  e.d_rdata = d_rdata;  e.d_stall = d_stall;
    e.src = src;
    return e;
  endfunction

  task automatic applyStimulus(input ins_t s);
    reset_n     = s.rst_n;
    l1i_req     = s.i_req;
    l1i_address = s.i_addr;
    l1d_req     = s.d_req;
    l1d_write   = s.d_wr;
    l1d_address = s.d_addr;
    l1d_wdata   = s.d_wdata;
    mem_ack     = s.ack;
    mem_rdata   = s.rdata;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input outs_t e);
    checkField({tag, ".mem_valid"},   32'(mem_valid),   32'(e.valid));
    checkField({tag, ".mem_write"},   32'(mem_write),   32'(e.write));
    checkField({tag, ".mem_address"}, mem_address,      e.addr);
    checkField({tag, ".mem_wdata"},   mem_wdata,        e.wdata);
    checkField({tag, ".l1i_done"},    32'(l1i_done),    32'(e.i_done));
    checkField({tag, ".l1i_rdata"},   l1i_rdata,        e.i_rdata);
    checkField({tag, ".stall_l1i"},   32'(stall_l1i),   32'(e.i_stall));
    checkField({tag, ".l1d_done"},    32'(l1d_done),    32'(e.d_done));
    checkField({tag, ".l1d_rdata"},   l1d_rdata,        e.d_rdata);
    checkField({tag, ".stall_l1d"},   32'(stall_l1d),   32'(e.d_stall));
    checkField({tag, ".data_source"}, 32'(data_source), 32'(e.src));
  endtask

  // One cycle: drive mid-cycle, then check outputs well away from the edge.
  task automatic step(input string tag, input ins_t s, input outs_t e);
    @(negedge clock);
    applyStimulus(s);
    #1;
    checkOutput(tag, e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[10];
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [1:0]  prev_src;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    logic        i_wins;
    logic [31:0] own_addr;
    logic [31:0] resp;

    // Single L1I read with a 3-cycle ack, then a zero-wait L1D store.
    vecs[0] = '{mk_in(1,1,32'h100,0,0,0,0,0,0),
                mk_out(0,0,32'h0,0,0,32'h0,1,0,0,0,SRC_NONE)};
    vecs[1] = '{mk_in(1,1,32'h100,0,0,0,0,0,0),
                mk_out(1,0,32'h100,0,0,32'h0,1,0,0,0,SRC_L1I)};
    vecs[2] = '{mk_in(1,1,32'h100,0,0,0,0,0,0),
                mk_out(1,0,32'h100,0,0,32'h0,1,0,0,0,SRC_L1I)};
    vecs[3] = '{mk_in(1,1,32'h100,0,0,0,0,1,32'hDEADBEEF),
                mk_out(1,0,32'h100,0,0,32'h0,1,0,0,0,SRC_L1I)};
    vecs[4] = '{mk_in(1,1,32'h100,0,0,0,0,0,0),
                mk_out(0,0,32'h100,0,1,32'hDEADBEEF,0,0,0,0,SRC_L1I)};
    vecs[5] = '{mk_in(1,0,32'h100,0,0,0,0,0,0),
                mk_out(0,0,32'h100,0,0,32'hDEADBEEF,0,0,0,0,SRC_L1I)};
    vecs[6] = '{mk_in(1,0,0,1,1,32'h2000,32'h12345678,0,0),
                mk_out(0,0,32'h100,0,0,32'hDEADBEEF,0,0,0,1,SRC_L1I)};
    vecs[7] = '{mk_in(1,0,0,1,1,32'h2000,32'h12345678,1,32'hAAAAAAAA),
                mk_out(1,1,32'h2000,32'h12345678,0,32'hDEADBEEF,0,0,0,1,SRC_L1D)};
    vecs[8] = '{mk_in(1,0,0,1,1,32'h2000,32'h12345678,0,0),
                mk_out(0,0,32'h2000,32'h12345678,0,32'hDEADBEEF,0,1,0,0,SRC_L1D)};
    vecs[9] = '{mk_in(1,0,0,0,0,0,0,0,0),
                mk_out(0,0,32'h2000,32'h12345678,0,32'hDEADBEEF,0,0,0,0,SRC_L1D)};

    applyStimulus(mk_in(0,0,0,0,0,0,0,0,0));
    repeat (2) @(posedge clock);
    step("reset", mk_in(0,0,0,0,0,0,0,0,0),
         mk_out(0,0,0,0,0,0,0,0,0,0,SRC_NONE));

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].stim, vecs[i].exp);
    end

    // Both requesters held: L1D wins four grants, then L1I, then the pattern repeats.
    prev_addr   = 32'h2000;
    prev_wdata  = 32'h12345678;
    prev_src    = SRC_L1D;
    exp_i_rdata = 32'hDEADBEEF;
    exp_d_rdata = 32'h0;
    for (int g = 0; g < 10; g++) begin
      i_wins   = (g == 4) || (g == 9);
      own_addr = i_wins ? 32'h300 : 32'h400;
      resp     = 32'hC0DE0000 + 32'(g);
      step($sformatf("starve%0d.idle", g), mk_in(1,1,32'h300,1,0,32'h400,0,0,0),
           mk_out(0,0,prev_addr,prev_wdata,0,exp_i_rdata,1,0,exp_d_rdata,1,prev_src));
      step($sformatf("starve%0d.busy", g), mk_in(1,1,32'h300,1,0,32'h400,0,1,resp),
           mk_out(1,0,own_addr,0,0,exp_i_rdata,1,0,exp_d_rdata,1,i_wins ? SRC_L1I : SRC_L1D));
      if (i_wins) exp_i_rdata = resp;
      else        exp_d_rdata = resp;
      step($sformatf("starve%0d.resp", g), mk_in(1,1,32'h300,1,0,32'h400,0,0,0),
           mk_out(0,0,own_addr,0,i_wins,exp_i_rdata,!i_wins,!i_wins,exp_d_rdata,i_wins,
                  i_wins ? SRC_L1I : SRC_L1D));
      prev_addr  = own_addr;
      prev_wdata = 32'h0;
      prev_src   = i_wins ? SRC_L1I : SRC_L1D;
    end

    // Fetch flushed while BUSY: the transaction completes but no done or rdata update.
    step("flush.idle", mk_in(1,1,32'h500,0,0,0,0,0,0),
         mk_out(0,0,32'h300,0,0,exp_i_rdata,1,0,exp_d_rdata,0,SRC_L1I));
    step("flush.busy0", mk_in(1,0,32'h500,0,0,0,0,0,0),
         mk_out(1,0,32'h500,0,0,exp_i_rdata,0,0,exp_d_rdata,0,SRC_L1I));
    step("flush.busy1", mk_in(1,0,32'h500,0,0,0,0,1,32'h55555555),
         mk_out(1,0,32'h500,0,0,exp_i_rdata,0,0,exp_d_rdata,0,SRC_L1I));
    step("flush.resp", mk_in(1,0,32'h500,0,0,0,0,0,0),
         mk_out(0,0,32'h500,0,0,exp_i_rdata,0,0,exp_d_rdata,0,SRC_L1I));
    step("flush.idle2", mk_in(1,0,0,1,0,32'h600,0,0,0),
         mk_out(0,0,32'h500,0,0,exp_i_rdata,0,0,exp_d_rdata,1,SRC_L1I));

    // Reset asserted while BUSY, followed by a late ack that must be ignored.
    step("rst.busy", mk_in(1,0,0,1,0,32'h600,0,0,0),
         mk_out(1,0,32'h600,0,0,exp_i_rdata,0,0,exp_d_rdata,1,SRC_L1D));
    step("rst.assert", mk_in(0,0,0,1,0,32'h600,0,0,0),
         mk_out(1,0,32'h600,0,0,exp_i_rdata,0,0,exp_d_rdata,1,SRC_L1D));
    step("rst.after", mk_in(1,0,0,0,0,0,0,1,32'h77777777),
         mk_out(0,0,0,0,0,0,0,0,0,0,SRC_NONE));
    step("rst.lateack", mk_in(1,0,0,0,0,0,0,1,32'h77777777),
         mk_out(0,0,0,0,0,0,0,0,0,0,SRC_NONE));
    step("rst.quiet", mk_in(1,0,0,0,0,0,0,0,0),
         mk_out(0,0,0,0,0,0,0,0,0,0,SRC_NONE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
